// File: rtl/conv_job_scheduler.sv
// conv_job_scheduler: walks an oc x row x col tile space and issues one addressed job per tile under a credit limit.
// Optional feature macro PERF_CNT_EN adds saturating busy/stall cycle counters (tied to 0 when undefined).
module conv_job_scheduler #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 128,
  parameter int CNT_WIDTH       = 8,
  parameter int FILTER_BYTES    = 36,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_global,
  input  logic [ADDR_WIDTH-1:0] base_ifm_addr,
  input  logic [ADDR_WIDTH-1:0] base_ofm_addr,
  input  logic [ADDR_WIDTH-1:0] base_filter_addr,
  input  logic [CNT_WIDTH-1:0]  num_oc,
  input  logic [CNT_WIDTH-1:0]  num_rows,
  input  logic [CNT_WIDTH-1:0]  num_cols,
  input  logic [ADDR_WIDTH-1:0] row_pitch,
  input  logic [ADDR_WIDTH-1:0] plane_pitch,
  output logic                  job_valid,
  input  logic                  job_ready,
  output logic [ADDR_WIDTH-1:0] job_ifm_addr,
  output logic [ADDR_WIDTH-1:0] job_ofm_addr,
  output logic [ADDR_WIDTH-1:0] job_filter_addr,
  output logic [CNT_WIDTH-1:0]  job_oc,
  output logic [CNT_WIDTH-1:0]  job_row,
  output logic [CNT_WIDTH-1:0]  job_col,
  output logic                  job_last,
  input  logic                  job_done,
  output logic                  busy,
  output logic                  done,
  output logic                  err_underflow,
  output logic [31:0]           perf_busy_cycles,
  output logic [31:0]           perf_stall_cycles
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES  = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] FILTER_STEP = ADDR_WIDTH'(FILTER_BYTES);
  localparam logic [OW-1:0]         MAX_OUT     = OW'(MAX_OUTSTANDING);
  localparam logic [OW-1:0]         OUT_ONE     = OW'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO    = CNT_WIDTH'(0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [OW-1:0]         out_q, out_d;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  noc_q, noc_d, nrow_q, nrow_d, ncol_q, ncol_d;
  logic [ADDR_WIDTH-1:0] base_ifm_q, base_ifm_d, rpitch_q, rpitch_d, ppitch_q, ppitch_d;
  logic [CNT_WIDTH-1:0]  oc_q, oc_d, row_q, row_d, col_q, col_d;
  logic [ADDR_WIDTH-1:0] ifm_q, ifm_d, ofm_q, ofm_d, filt_q, filt_d;
  logic [ADDR_WIDTH-1:0] row_ifm_q, row_ifm_d, row_ofm_q, row_ofm_d, oc_ofm_q, oc_ofm_d;
  logic                  last_q, last_d;

  logic start_acc_s, cnt_zero_s, accept_s, underflow_s;

  assign start_acc_s = (state_q == S_IDLE) && start_global;
  assign cnt_zero_s  = (num_oc == CNT_ZERO) || (num_rows == CNT_ZERO) || (num_cols == CNT_ZERO);
  assign accept_s    = job_valid && job_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_acc_s) begin
          state_d = cnt_zero_s ? S_DONE : S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (accept_s && last_q) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_ISSUE;
        end
      end
      // Leave DRAIN on the same edge that retires the final outstanding job.
      S_DRAIN: begin
        if (out_d == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    job_valid = (state_q == S_ISSUE) && (out_q < MAX_OUT);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
  end

  // A retire with nothing outstanding is dropped and flagged unless an accept cancels it.
  always_comb begin
    out_d       = out_q;
    underflow_s = 1'b0;
    if (accept_s && !job_done) begin
      out_d = out_q + OUT_ONE;
    end else if (!accept_s && job_done) begin
      if (out_q == '0) begin
        underflow_s = 1'b1;
      end else begin
        out_d = out_q - OUT_ONE;
      end
    end else begin
      out_d = out_q;
    end
    if (start_acc_s) begin
      err_d = 1'b0;
    end else if (underflow_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  always_comb begin
    noc_d = noc_q;  nrow_d = nrow_q;  ncol_d = ncol_q;
    base_ifm_d = base_ifm_q;  rpitch_d = rpitch_q;  ppitch_d = ppitch_q;
    oc_d = oc_q;  row_d = row_q;  col_d = col_q;
    ifm_d = ifm_q;  ofm_d = ofm_q;  filt_d = filt_q;
    row_ifm_d = row_ifm_q;  row_ofm_d = row_ofm_q;  oc_ofm_d = oc_ofm_q;
    last_d = last_q;
    if (start_acc_s) begin
      noc_d = num_oc;  nrow_d = num_rows;  ncol_d = num_cols;
      base_ifm_d = base_ifm_addr;  rpitch_d = row_pitch;  ppitch_d = plane_pitch;
      oc_d = CNT_ZERO;  row_d = CNT_ZERO;  col_d = CNT_ZERO;
      ifm_d = base_ifm_addr;  row_ifm_d = base_ifm_addr;
      ofm_d = base_ofm_addr;  row_ofm_d = base_ofm_addr;  oc_ofm_d = base_ofm_addr;
      filt_d = base_filter_addr;
      last_d = (num_oc == CNT_ONE) && (num_rows == CNT_ONE) && (num_cols == CNT_ONE);
    end else if (accept_s) begin
      // Each address keeps a running base per loop level so only adders are needed.
      if (col_q != ncol_q - CNT_ONE) begin
        col_d = col_q + CNT_ONE;
        ifm_d = ifm_q + BEAT_BYTES;
        ofm_d = ofm_q + BEAT_BYTES;
      end else if (row_q != nrow_q - CNT_ONE) begin
        col_d     = CNT_ZERO;
        row_d     = row_q + CNT_ONE;
        row_ifm_d = row_ifm_q + rpitch_q;
        ifm_d     = row_ifm_q + rpitch_q;
        row_ofm_d = row_ofm_q + rpitch_q;
        ofm_d     = row_ofm_q + rpitch_q;
      end else begin
        col_d     = CNT_ZERO;
        row_d     = CNT_ZERO;
        oc_d      = oc_q + CNT_ONE;
        row_ifm_d = base_ifm_q;
        ifm_d     = base_ifm_q;
        oc_ofm_d  = oc_ofm_q + ppitch_q;
        row_ofm_d = oc_ofm_q + ppitch_q;
        ofm_d     = oc_ofm_q + ppitch_q;
        filt_d    = filt_q + FILTER_STEP;
      end
      last_d = (oc_d == noc_q - CNT_ONE) && (row_d == nrow_q - CNT_ONE) && (col_d == ncol_q - CNT_ONE);
    end else begin
      last_d = last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;  err_q <= 1'b0;
      noc_q <= '0;  nrow_q <= '0;  ncol_q <= '0;
      base_ifm_q <= '0;  rpitch_q <= '0;  ppitch_q <= '0;
      oc_q <= '0;  row_q <= '0;  col_q <= '0;
      ifm_q <= '0;  ofm_q <= '0;  filt_q <= '0;
      row_ifm_q <= '0;  row_ofm_q <= '0;  oc_ofm_q <= '0;
      last_q <= 1'b0;
    end else begin
      out_q <= out_d;  err_q <= err_d;
      noc_q <= noc_d;  nrow_q <= nrow_d;  ncol_q <= ncol_d;
      base_ifm_q <= base_ifm_d;  rpitch_q <= rpitch_d;  ppitch_q <= ppitch_d;
      oc_q <= oc_d;  row_q <= row_d;  col_q <= col_d;
      ifm_q <= ifm_d;  ofm_q <= ofm_d;  filt_q <= filt_d;
      row_ifm_q <= row_ifm_d;  row_ofm_q <= row_ofm_d;  oc_ofm_q <= oc_ofm_d;
      last_q <= last_d;
    end
  end

  assign job_ifm_addr    = ifm_q;
  assign job_ofm_addr    = ofm_q;
  assign job_filter_addr = filt_q;
  assign job_oc          = oc_q;
  assign job_row         = row_q;
  assign job_col         = col_q;
  assign job_last        = last_q;
  assign err_underflow   = err_q;

`ifdef PERF_CNT_EN
  logic [31:0] pbusy_q, pstall_q;

  always_ff @(posedge clk) begin
    if (rst || start_acc_s) begin
      pbusy_q  <= 32'd0;
      pstall_q <= 32'd0;
    end else begin
      if (busy && (pbusy_q != 32'hFFFF_FFFF)) begin
        pbusy_q <= pbusy_q + 32'd1;
      end else begin
        pbusy_q <= pbusy_q;
      end
      if (job_valid && !job_ready && (pstall_q != 32'hFFFF_FFFF)) begin
        pstall_q <= pstall_q + 32'd1;
      end else begin
        pstall_q <= pstall_q;
      end
    end
  end

  assign perf_busy_cycles  = pbusy_q;
  assign perf_stall_cycles = pstall_q;
`else
  assign perf_busy_cycles  = 32'd0;
  assign perf_stall_cycles = 32'd0;
`endif

endmodule

// File: doc/conv_job_scheduler.md
Name: conv_job_scheduler

Overview:
Parametrised successor to the single-shot convolution scheduler. It walks a runtime-configurable output-channel × row × column tile space and issues one compute job per tile over a valid/ready handshake. Each job carries IFM, filter and OFM byte addresses. It limits in-flight jobs with an outstanding-job credit counter and reports completion once every issued job has retired. It sits between the host/control logic and the MAC array / BRAM address ports.

Parameters:
ADDR_WIDTH, 32, byte-address width; all address arithmetic is modulo 2^ADDR_WIDTH
DATA_WIDTH, 128, BRAM beat width; column step BEAT_BYTES = DATA_WIDTH/8
CNT_WIDTH, 8, width of the oc/row/col count inputs and of the job index fields
FILTER_BYTES, 36, filter-address step per output channel
MAX_OUTSTANDING, 4, maximum number of accepted but not yet retired jobs (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start_global  in  1  start request; sampled only in IDLE
base_ifm_addr  in  ADDR_WIDTH  IFM base; latched on start
base_ofm_addr  in  ADDR_WIDTH  OFM base; latched on start
base_filter_addr  in  ADDR_WIDTH  filter base; latched on start
num_oc, num_rows, num_cols  in  CNT_WIDTH each  tile counts; latched on start
row_pitch  in  ADDR_WIDTH  bytes per row; latched on start
plane_pitch  in  ADDR_WIDTH  OFM bytes per output channel; latched on start
job_valid  out  1  job presented
job_ready  in  1  consumer accepts the job
job_ifm_addr, job_ofm_addr, job_filter_addr  out  ADDR_WIDTH each  job addresses
job_oc, job_row, job_col  out  CNT_WIDTH each  job indices
job_last  out  1  marks the final job of the run
job_done  in  1  one-cycle retire pulse from the compute side
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
err_underflow  out  1  sticky; cleared on an accepted start
perf_busy_cycles, perf_stall_cycles  out  32 each  performance counters (see Optional Feature)

Behaviour:
- Reset (synchronous, takes priority over everything including a run in progress):
  - state = IDLE.
  - All outputs 0; outstanding = 0; indices = 0.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start_global=1 in cycle N latches all configuration inputs and clears err_underflow.
  - If any count is 0: go to DONE; done=1 in N+1; no job is issued.
  - Otherwise: go to ISSUE; job_valid=1 from N+1 with job (0,0,0).
  - start_global outside IDLE is ignored.
- Job addressing (registered outputs, computed by incremental adders only, no multipliers):
  - ifm = base_ifm + row*row_pitch + col*BEAT_BYTES
  - filter = base_filter + oc*FILTER_BYTES
  - ofm = base_ofm + oc*plane_pitch + row*row_pitch + col*BEAT_BYTES
- Loop order: col innermost, then row, then oc.
- job_last=1 only when oc=num_oc-1, row=num_rows-1 and col=num_cols-1.
- Handshake:
  - Accept = job_valid & job_ready. Once asserted, job_valid and all job fields stay stable until accepted.
  - After an accept, the next job appears the following cycle, giving back-to-back throughput of 1 job/cycle.
- Credit limit:
  - job_valid = (state==ISSUE) & (outstanding < MAX_OUTSTANDING).
  - Accept increments outstanding; job_done decrements it.
  - Accept and job_done in the same cycle leave outstanding unchanged.
  - job_done with outstanding=0 (and no simultaneous accept) is ignored and sets err_underflow.
- ISSUE → DRAIN when the job_last job is accepted.
- DRAIN → DONE in the cycle outstanding becomes 0. If outstanding is already 0, the transition happens on the cycle after entering DRAIN.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 in IDLE only.

Optional Feature:
PERF_CNT_EN:
- Defined:
  - perf_busy_cycles counts cycles with busy=1.
  - perf_stall_cycles counts cycles with job_valid=1 and job_ready=0.
  - Both counters clear on an accepted start and saturate at 2^32-1.
- Undefined: both ports tie to constant 0; no counter flops are inferred.

Test Plan:
1. Reset, start with num_oc=1, num_rows=1, num_cols=4, bases 0, row_pitch=64, job_ready=1, job_done 2 cycles after each accept:
   - 4 jobs, ifm addresses 0x00/0x10/0x20/0x30.
   - job_last only on the 4th job.
   - done pulses once, after the 4th retire.
2. num_oc=2, num_rows=2, num_cols=2, row_pitch=0x40, plane_pitch=0x100, base_filter=0x1000:
   - Job order and addresses match the formulas.
   - oc=1,row=1,col=1 gives ofm=0x150 and filter=0x1024.
3. MAX_OUTSTANDING=4, job_ready=1, job_done held 0 for 20 cycles:
   - Exactly 4 accepts, then job_valid=0.
   - Releasing one job_done re-enables exactly one issue.
4. job_ready toggling randomly:
   - Fields stay stable while valid & !ready; no job is skipped or duplicated.
   - With PERF_CNT_EN, perf_stall_cycles equals the count of valid & !ready cycles.
5. Error and edge cases:
   - num_cols=0: done pulses the cycle after start and job_valid never rises.
   - Stray job_done in IDLE: err_underflow=1, then cleared by the next start.
6. Reset asserted mid-ISSUE with 3 outstanding:
   - Next cycle: IDLE, busy=0, job_valid=0, outstanding=0.
   - A subsequent start runs cleanly.
